// File: rtl/bool_pkg.sv
// bool_pkg: shared state, index and truth-table constants for the boolean unit and its inference helper.
package bool_pkg;

   typedef enum logic [1:0] {
      BI_IDLE    = 2'd0,
      BI_COLLECT = 2'd1,
      BI_DONE    = 2'd2
   } bi_state_e;

   localparam logic [1:0] BI_IDX_00 = 2'd0;
   localparam logic [1:0] BI_IDX_01 = 2'd1;
   localparam logic [1:0] BI_IDX_10 = 2'd2;
   localparam logic [1:0] BI_IDX_11 = 2'd3;

   localparam logic [3:0] FN_AND  = 4'b1000;
   localparam logic [3:0] FN_OR   = 4'b1110;
   localparam logic [3:0] FN_XOR  = 4'b0110;
   localparam logic [3:0] FN_NAND = 4'b0111;
   localparam logic [3:0] FN_NOR  = 4'b0001;
   localparam logic [3:0] FN_XNOR = 4'b1001;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (&v) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/bool_sample_scan.sv
// bool_sample_scan: reduces one (a, b, r) sample to per-entry "seen 1" / "seen 0" flags.
module bool_sample_scan #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] in_a_i,
   input  logic [WIDTH-1:0] in_b_i,
   input  logic [WIDTH-1:0] in_r_i,
   output logic [3:0]       ones_o,
   output logic [3:0]       zeros_o
);

   for (genvar k = 0; k < 4; k++) begin : g_idx
      localparam logic [1:0] K = 2'(k);
      logic [WIDTH-1:0] w_sel;
      assign w_sel      = ~(in_a_i ^ {WIDTH{K[1]}}) & ~(in_b_i ^ {WIDTH{K[0]}});
      assign ones_o[k]  = |(w_sel & in_r_i);
      assign zeros_o[k] = |(w_sel & ~in_r_i);
   end

endmodule

// File: rtl/bool_fn_infer.sv
// bool_fn_infer: reconstructs a 4-entry truth table from (a, b, r) samples.
// Optional BOOL_INFER_STATS_EN adds a saturating per-inference sample counter.
module bool_fn_infer
   import bool_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             clear_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_a_i,
   input  logic [WIDTH-1:0] in_b_i,
   input  logic [WIDTH-1:0] in_r_i,
   input  logic             in_last_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [3:0]       fn_o,
   output logic [3:0]       known_o,
   output logic             conflict_o
`ifdef BOOL_INFER_STATS_EN
   ,
   output logic [15:0]      sample_cnt_o
`endif
);

   bi_state_e  r_state;
   logic       r_in_ready;
   logic       r_res_valid;
   logic [3:0] r_fn;
   logic [3:0] r_known;
   logic       r_conflict;

   logic [3:0] w_ones;
   logic [3:0] w_zeros;
   logic       w_collect;
   logic       w_accept;
   logic [3:0] w_base_fn;
   logic [3:0] w_base_known;
   logic       w_base_conflict;
   logic [3:0] w_entry_conflict;
   logic [3:0] w_new_fn;
   logic [3:0] w_new_known;
   logic       w_new_conflict;
   logic       w_term;

   bool_sample_scan #(.WIDTH(WIDTH)) u_scan (
      .in_a_i  (in_a_i),
      .in_b_i  (in_b_i),
      .in_r_i  (in_r_i),
      .ones_o  (w_ones),
      .zeros_o (w_zeros)
   );

   // A sample accepted in IDLE starts from empty state; only COLLECT carries history.
   assign w_collect        = r_state == BI_COLLECT;
   assign w_accept         = in_valid_i & r_in_ready;
   assign w_base_fn        = w_collect ? r_fn : 4'd0;
   assign w_base_known     = w_collect ? r_known : 4'd0;
   assign w_base_conflict  = w_collect & r_conflict;
   assign w_entry_conflict = (w_ones & w_zeros)
                           | (w_base_known & ((w_base_fn & w_zeros) | (~w_base_fn & w_ones)));
   assign w_new_known      = w_base_known | w_ones | w_zeros;
   assign w_new_fn         = w_base_fn | w_ones;
   assign w_new_conflict   = w_base_conflict | (|w_entry_conflict);
   assign w_term           = in_last_i | (&w_new_known) | w_new_conflict;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state     <= BI_IDLE;
         r_in_ready  <= 1'b1;
         r_res_valid <= 1'b0;
         r_fn        <= 4'd0;
         r_known     <= 4'd0;
         r_conflict  <= 1'b0;
      end else if (clear_i) begin
         r_state     <= BI_IDLE;
         r_in_ready  <= 1'b1;
         r_res_valid <= 1'b0;
         r_fn        <= 4'd0;
         r_known     <= 4'd0;
         r_conflict  <= 1'b0;
      end else if (w_accept) begin
         r_state     <= w_term ? BI_DONE : BI_COLLECT;
         r_in_ready  <= ~w_term;
         r_res_valid <= w_term;
         r_fn        <= w_new_fn;
         r_known     <= w_new_known;
         r_conflict  <= w_new_conflict;
      end else if (r_state == BI_DONE && res_ready_i) begin
         r_state     <= BI_IDLE;
         r_in_ready  <= 1'b1;
         r_res_valid <= 1'b0;
      end
   end

`ifdef BOOL_INFER_STATS_EN
   logic [15:0] r_cnt;
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         r_cnt <= 16'd0;
      else if (clear_i)
         r_cnt <= 16'd0;
      else if (w_accept)
         r_cnt <= sat_inc16(w_collect ? r_cnt : 16'd0);
   end
   assign sample_cnt_o = r_cnt;
`endif

   assign in_ready_o  = r_in_ready;
   assign res_valid_o = r_res_valid;
   assign fn_o        = r_fn;
   assign known_o     = r_known;
   assign conflict_o  = r_conflict;

endmodule

// File: tb/tb_bool_fn_infer.sv
// tb_bool_fn_infer: randomized and directed checks of bool_fn_infer against a per-entry observation model.
module tb_bool_fn_infer;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         clear = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic [W-1:0] in_r = '0;
   logic         in_last = 1'b0;
   logic         res_valid;
   logic         res_ready = 1'b0;
   logic [3:0]   fn;
   logic [3:0]   known;
   logic         conflict;
`ifdef BOOL_INFER_STATS_EN
   logic [15:0]  sample_cnt;
`endif

   int errors = 0;
   int checks = 0;

   bool_fn_infer #(.WIDTH(W)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .clear_i     (clear),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_a_i      (in_a),
      .in_b_i      (in_b),
      .in_r_i      (in_r),
      .in_last_i   (in_last),
      .res_valid_o (res_valid),
      .res_ready_i (res_ready),
      .fn_o        (fn),
      .known_o     (known),
      .conflict_o  (conflict)
`ifdef BOOL_INFER_STATS_EN
      ,
      .sample_cnt_o(sample_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Model: which values each truth-table entry has been seen producing in this inference.
   logic [3:0] m_s0 = '0, m_s1 = '0;
   logic       m_conf = 1'b0;
   int         m_mode = 0;
   int         m_cnt = 0;

   always @(posedge clk or negedge rst_n) begin : mdl
      logic [3:0] t0, t1;
      logic [1:0] e;
      int         tc;
      if (!rst_n) begin
         m_s0 <= '0; m_s1 <= '0; m_conf <= 1'b0; m_mode <= 0; m_cnt <= 0;
      end else if (clear) begin
         m_s0 <= '0; m_s1 <= '0; m_conf <= 1'b0; m_mode <= 0; m_cnt <= 0;
      end else if (in_valid && m_mode != 2) begin
         t0 = (m_mode == 0) ? 4'd0 : m_s0;
         t1 = (m_mode == 0) ? 4'd0 : m_s1;
         tc = (m_mode == 0) ? 0 : m_cnt;
         for (int i = 0; i < W; i++) begin
            e = {in_a[i], in_b[i]};
            if (in_r[i]) t1[e] = 1'b1; else t0[e] = 1'b1;
         end
         m_s0   <= t0;
         m_s1   <= t1;
         m_conf <= |(t0 & t1);
         m_cnt  <= (tc < 65535) ? tc + 1 : tc;
         m_mode <= (in_last || (t0 | t1) == 4'hF || (|(t0 & t1))) ? 2 : 1;
      end else if (m_mode == 2 && res_ready) begin
         m_mode <= 0;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("in_ready", 32'(in_ready), 32'(m_mode != 2));
         chk("res_valid", 32'(res_valid), 32'(m_mode == 2));
         chk("fn", 32'(fn), 32'(m_s1));
         chk("known", 32'(known), 32'(m_s0 | m_s1));
         chk("conflict", 32'(conflict), 32'(m_conf));
`ifdef BOOL_INFER_STATS_EN
         chk("sample_cnt", 32'(sample_cnt), 32'(m_cnt));
`endif
      end
   end

   task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] r, input logic last, input logic rr, input logic clr);
      in_valid = v; in_a = a; in_b = b; in_r = r; in_last = last; res_ready = rr; clear = clr;
      @(negedge clk);
   endtask

   task automatic release_result();
      step(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
      chk("release_ready", 32'(in_ready), 32'd1);
   endtask

   function automatic logic [W-1:0] apply_fn(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = f[{a[i], b[i]}];
      return r;
   endfunction

   initial begin
      logic [3:0]   rf;
      logic [W-1:0] ra, rb;
      #7;
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_valid", 32'(res_valid), 32'd0);
      chk("rst_outs", {23'd0, conflict, known, fn}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      step(1'b1, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b0);
      chk("and_valid", 32'(res_valid), 32'd1);
      chk("and_fn", 32'(fn), 32'b1000);
      chk("and_known", 32'(known), 32'b1111);
      chk("and_conf", 32'(conflict), 32'd0);
      chk("and_ready", 32'(in_ready), 32'd0);
      release_result();

      step(1'b1, 4'h1, 4'h0, 4'h1, 1'b1, 1'b0, 1'b0);
      chk("part_fn", 32'(fn), 32'b0100);
      chk("part_known", 32'(known), 32'b0101);
      chk("part_conf", 32'(conflict), 32'd0);
      release_result();

      step(1'b1, 4'h3, 4'h3, 4'h1, 1'b0, 1'b0, 1'b0);
      chk("intra_valid", 32'(res_valid), 32'd1);
      chk("intra_conf", 32'(conflict), 32'd1);
      chk("intra_known", 32'(known), 32'b1001);
      release_result();

      step(1'b1, 4'h1, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0);
      chk("cross1_valid", 32'(res_valid), 32'd0);
      step(1'b1, 4'h1, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0);
      chk("cross_conf", 32'(conflict), 32'd1);
      chk("cross_fn", 32'(fn), 32'b1000);
      chk("cross_known", 32'(known), 32'b1001);
      release_result();

      step(1'b1, 4'hC, 4'hA, 4'h6, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b0);
         chk("bp_fn", 32'(fn), 32'b0110);
         chk("bp_valid", 32'(res_valid), 32'd1);
      end
      release_result();
      chk("bp_idle_valid", 32'(res_valid), 32'd0);
      step(1'b1, 4'h1, 4'h0, 4'h1, 1'b1, 1'b0, 1'b0);
      chk("bp_fresh_known", 32'(known), 32'b0101);
      release_result();

      step(1'b1, 4'h1, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b1);
      chk("clr_known", 32'(known), 32'd0);
      chk("clr_valid", 32'(res_valid), 32'd0);
      step(1'b1, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b0);
      chk("clr_and_fn", 32'(fn), 32'b1000);
      release_result();

      step(1'b1, 4'h1, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_outs", {23'd0, conflict, known, fn}, 32'd0);
      chk("arst_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b0);
      chk("arst_and_fn", 32'(fn), 32'b1000);
      chk("arst_and_conf", 32'(conflict), 32'd0);
      release_result();

      for (int n = 0; n < 600; n++) begin
         rf = 4'($urandom);
         ra = W'($urandom);
         rb = W'($urandom);
         step($urandom_range(3) != 0, ra, rb,
              ($urandom_range(7) == 0) ? W'($urandom) : apply_fn(rf, ra, rb),
              $urandom_range(3) == 0, $urandom_range(2) != 0, $urandom_range(31) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bool_fn_infer.md
Name: bool_fn_infer

Overview:
- Inverse of the datapath's 4-bit truth-table boolean unit. That unit computes r[i] = fn[{a[i],b[i]}] from a, b and fn.
- This block receives a stream of (a, b, r) word samples and reconstructs fn, with a per-entry known mask and a conflict flag.
- Sits beside the boolean ALU as a self-check/trace helper: fed from a retire-side monitor, result read by a debug/CSR consumer.

Parameters:
- WIDTH, 32, bit width of a/b/r sample words (>=1).

Ports:
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous abort: discard accumulation, return to IDLE
- in_valid_i  in  1  sample valid
- in_ready_o  out  1  block can accept a sample
- in_a_i  in  WIDTH  operand a
- in_b_i  in  WIDTH  operand b
- in_r_i  in  WIDTH  observed result
- in_last_i  in  1  final sample of this inference
- res_valid_o  out  1  result valid
- res_ready_i  in  1  consumer takes result
- fn_o  out  4  inferred truth table; bit k = output for {a,b}=k; unknown entries read 0
- known_o  out  4  bit k set once entry k has been observed
- conflict_o  out  1  contradictory observation seen

Behaviour:
- Reset (async, rst_n_i=0):
  - state=IDLE, in_ready_o=1, res_valid_o=0.
  - fn_o=0, known_o=0, conflict_o=0.
- States: IDLE, COLLECT, DONE. in_ready_o=1 in IDLE/COLLECT and 0 in DONE; it is a registered function of state.
- Sample reduction (combinational), per index k in 0..3:
  - sel_k[i] = ({a[i],b[i]}==k).
  - ones_k = |(sel_k & r); zeros_k = |(sel_k & ~r).
- Merge on accept (in_valid_i & in_ready_o):
  - Base is the current registers in COLLECT, or zero in IDLE (a fresh inference starts from empty state).
  - new_known = base_known | ones | zeros.
  - new_fn = base_fn | ones.
  - conflict for entry k = (ones_k & zeros_k) | (base_known[k] & ((base_fn[k] & zeros_k) | (~base_fn[k] & ones_k))).
  - new_conflict = base_conflict | (OR of the per-entry conflicts).
- Transitions on an accepting cycle:
  - To DONE if in_last_i, new_known==4'b1111, or new_conflict.
  - Otherwise to COLLECT.
- DONE:
  - res_valid_o=1, with fn_o/known_o/conflict_o held stable until res_ready_i.
  - On res_valid_o & res_ready_i: go to IDLE next cycle. Registers keep their values; the next sample restarts from zero.
- Latency: result visible (res_valid_o=1) the cycle after the terminating sample is accepted.
- Throughput: one sample per cycle in COLLECT, no bubbles.
- clear_i has the highest priority:
  - Next state IDLE; fn/known/conflict cleared.
  - A sample presented in the same cycle is dropped.
  - In DONE, a pending result is discarded.
- Conflict is sticky for the inference. On a conflicting entry, fn keeps the OR of all observed ones.
- in_valid_i while in DONE: not accepted; the producer must hold the sample.
- Reset mid-operation: async return to the reset values above, regardless of state or handshake.

Optional Feature:
- BOOL_INFER_STATS_EN defined:
  - Adds output sample_cnt_o, 16 bits: count of samples accepted in the current inference.
  - Saturates at 16'hFFFF.
  - Cleared by reset, clear_i, and on the first sample accepted in IDLE (set to 1).
  - Frozen in DONE.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package/header bool_pkg:
  - State encoding constants BI_IDLE=2'd0, BI_COLLECT=2'd1, BI_DONE=2'd2.
  - Index constants BI_IDX_00..BI_IDX_11.
  - Truth-table constants for common ops, e.g. FN_AND=4'b1000, FN_OR=4'b1110, FN_XOR=4'b0110, shared with the boolean unit's decoder.
- Sub-module bool_sample_scan: purely combinational WIDTH-parameterised reducer, (a, b, r) -> ones[3:0], zeros[3:0]. The top holds the FSM, merge and output registers.

Test Plan:
- AND: a=0xC, b=0xA, r=0x8, last=0 -> all entries known after one sample. Next cycle res_valid_o=1, fn_o=4'b1000, known_o=4'b1111, conflict_o=0, in_ready_o=0.
- Partial, last-terminated: a=0x1, b=0x0, r=0x1, last=1 -> next cycle fn_o=4'b0100, known_o=4'b0101, conflict_o=0.
- Intra-sample conflict: a=0x3, b=0x3, r=0x1 -> DONE next cycle, conflict_o=1, known_o=4'b1001.
- Cross-sample conflict and back-to-back accept:
  - Sample 1: a=0x1, b=0x1, r=0x1, last=0 -> COLLECT.
  - Sample 2 (next cycle): a=0x1, b=0x1, r=0x0 -> conflict_o=1, fn_o=4'b1000, known_o=4'b1001.
- Backpressure: XOR sample (a=0xC, b=0xA, r=0x6) with res_ready_i=0 for 3 cycles -> outputs stable at 4'b0110, in_valid_i ignored.
  - Then res_ready_i=1 -> IDLE next cycle.
  - A new sample starts from zero; known_o is not carried over.
- Abort and reset: clear_i mid-COLLECT, and separately rst_n_i pulsed low mid-COLLECT asynchronously.
  - Each -> IDLE; reset also forces all outputs to 0 immediately.
  - Subsequent AND sample gives fn_o=4'b1000 with no residue.
